// File: rtl/reward_scheduler.sv
// Reward sequencing: paces spawns, shows one reward for a bounded life, detects collection
// and runs four independent effect-duration timers for the game/tank/display logic.
module reward_scheduler #(
    parameter int GAP_TICKS    = 8,
    parameter int LIFE_TICKS   = 40,
    parameter int EFFECT_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic       mode_infinity,
    input  logic       spawn_valid,
    input  logic [2:0] spawn_type,
    input  logic [4:0] spawn_xpos,
    input  logic [4:0] spawn_ypos,
    input  logic [4:0] mytank_xpos,
    input  logic [4:0] mytank_ypos,
    output logic       spawn_req,
    output logic       spawn_ack,
    output logic       icon_visible,
    output logic [4:0] icon_xpos,
    output logic [4:0] icon_ypos,
    output logic [2:0] icon_type,
    output logic       reward_invincible,
    output logic       reward_faster,
    output logic       reward_frozen,
    output logic       reward_laser,
    output logic       reward_addtime,
    output logic       collect_pulse,
    output logic [7:0] effect_remaining,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_REQ  = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic [7:0] GAP_L  = 8'(GAP_TICKS);
    localparam logic [7:0] LIFE_L = 8'(LIFE_TICKS);
    localparam logic [7:0] EFF_L  = 8'(EFFECT_TICKS);

    state_t     state_q, state_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] life_q, life_d;
    logic [4:0] icon_x_q, icon_x_d;
    logic [4:0] icon_y_q, icon_y_d;
    logic [2:0] icon_t_q, icon_t_d;
    logic [7:0] inv_q, fast_q, frz_q, las_q;
    logic       load_inv, load_fast, load_frz, load_las;
    logic       hit;
    logic [7:0] max_a, max_b;

    assign hit = (icon_x_q == mytank_xpos) && (icon_y_q == mytank_ypos);

    // Handshake: spawn_req is a level held in REQ; a cycle with spawn_req && spawn_valid
    // is the transfer, marked by spawn_ack in that same cycle, and the request drops next clk.
    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        life_d         = life_q;
        icon_x_d       = icon_x_q;
        icon_y_d       = icon_y_q;
        icon_t_d       = icon_t_q;
        spawn_req      = 1'b0;
        spawn_ack      = 1'b0;
        icon_visible   = 1'b0;
        collect_pulse  = 1'b0;
        reward_addtime = 1'b0;
        load_inv       = 1'b0;
        load_fast      = 1'b0;
        load_frz       = 1'b0;
        load_las       = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    gap_d   = GAP_L;
                    state_d = S_GAP;
                end
                S_GAP: begin
                    if (tick) begin
                        if (gap_q <= 8'd1) begin
                            gap_d   = 8'd0;
                            state_d = S_REQ;
                        end else begin
                            gap_d = gap_q - 8'd1;
                        end
                    end
                end
                S_REQ: begin
                    spawn_req = 1'b1;
                    if (spawn_valid) begin
                        spawn_ack = 1'b1;
                        icon_x_d  = spawn_xpos;
                        icon_y_d  = spawn_ypos;
                        icon_t_d  = spawn_type;
                        if (spawn_type >= 3'd1 && spawn_type <= 3'd4) begin
                            life_d  = LIFE_L;
                            state_d = S_SHOW;
                        end else begin
                            gap_d   = GAP_L;
                            state_d = S_GAP;
                        end
                    end
                end
                S_SHOW: begin
                    icon_visible = 1'b1;
                    // Collection is checked before life expiry so a same-clk tie is collected.
                    if (hit) begin
                        collect_pulse = 1'b1;
                        case (icon_t_q)
                            3'd1: begin
                                if (mode_infinity) reward_addtime = 1'b1;
                                else               load_inv       = 1'b1;
                            end
                            3'd2:    load_fast = 1'b1;
                            3'd3:    load_frz  = 1'b1;
                            3'd4:    load_las  = 1'b1;
                            default: ;
                        endcase
                        gap_d   = GAP_L;
                        state_d = S_GAP;
                    end else if (tick) begin
                        if (life_q <= 8'd1) begin
                            life_d  = 8'd0;
                            gap_d   = GAP_L;
                            state_d = S_GAP;
                        end else begin
                            life_d = life_q - 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    function automatic logic [7:0] eff_next(input logic [7:0] cnt, input logic ld,
                                            input logic en, input logic tk);
        logic [7:0] n;
        n = cnt;
        if (!en)                         n = 8'd0;
        else if (ld)                     n = EFF_L;
        else if (tk && (cnt != 8'd0))    n = cnt - 8'd1;
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gap_q    <= 8'd0;
            life_q   <= 8'd0;
            icon_x_q <= 5'd0;
            icon_y_q <= 5'd0;
            icon_t_q <= 3'd0;
            inv_q    <= 8'd0;
            fast_q   <= 8'd0;
            frz_q    <= 8'd0;
            las_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            life_q   <= life_d;
            icon_x_q <= icon_x_d;
            icon_y_q <= icon_y_d;
            icon_t_q <= icon_t_d;
            inv_q    <= eff_next(inv_q,  load_inv,  enable, tick);
            fast_q   <= eff_next(fast_q, load_fast, enable, tick);
            frz_q    <= eff_next(frz_q,  load_frz,  enable, tick);
            las_q    <= eff_next(las_q,  load_las,  enable, tick);
        end
    end

    assign max_a            = (inv_q > fast_q) ? inv_q : fast_q;
    assign max_b            = (frz_q > las_q) ? frz_q : las_q;
    assign effect_remaining = (max_a > max_b) ? max_a : max_b;

    assign icon_xpos         = icon_x_q;
    assign icon_ypos         = icon_y_q;
    assign icon_type         = icon_t_q;
    assign reward_invincible = (inv_q != 8'd0);
    assign reward_faster     = (fast_q != 8'd0);
    assign reward_frozen     = (frz_q != 8'd0);
    assign reward_laser      = (las_q != 8'd0);
    assign dbg_state         = state_q;

endmodule
